// File: rtl/legv8_ctrl_pkg.sv
// Shared LEGv8 control-path definitions: control-word layout, Psel codes,
// branch opcode patterns, condition codes and the branch sequencer states.
package legv8_ctrl_pkg;

    typedef enum logic [1:0] {
        PSEL_HOLD = 2'b00,
        PSEL_PC4  = 2'b01,
        PSEL_PCK  = 2'b10,
        PSEL_REG  = 2'b11
    } psel_e;

    // Field order is the bit order of the 31-bit control word, MSB first.
    typedef struct packed {
        psel_e      psel;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] fsel;
        logic       reg_w;
        logic       ram_w;
        logic       en_mem;
        logic       en_alu;
        logic       en_b;
        logic       en_pc;
        logic       bsel;
        logic       pcsel;
        logic       sl;
    } ctrl_word_t;

    localparam logic [4:0] REG_ZR     = 5'd31;
    localparam logic [4:0] ALU_PASS_A = 5'b00111;

    localparam ctrl_word_t CW_NOP = '{
        psel:   PSEL_HOLD,
        da:     REG_ZR,
        sa:     5'd0,
        sb:     REG_ZR,
        fsel:   5'd0,
        reg_w:  1'b0,
        ram_w:  1'b0,
        en_mem: 1'b0,
        en_alu: 1'b0,
        en_b:   1'b0,
        en_pc:  1'b0,
        bsel:   1'b0,
        pcsel:  1'b0,
        sl:     1'b0
    };

    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [21:0] OP_BR    = 22'b1101011000011111000000;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;

    typedef enum logic [3:0] {
        CC_EQ, CC_NE, CC_HS, CC_LO, CC_MI, CC_PL, CC_VS, CC_VC,
        CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
    } cond_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LINK,
        ST_TEST,
        ST_EXEC,
        ST_ERR
    } seq_state_e;

    typedef enum logic [2:0] {
        BR_ILLEGAL,
        BR_B,
        BR_BL,
        BR_BR,
        BR_CBZ,
        BR_CBNZ,
        BR_BCOND
    } br_class_e;

    // BR is checked first: its long pattern is the most specific match.
    function automatic br_class_e decode_class(input logic [31:0] ins);
        br_class_e cls;
        cls = BR_ILLEGAL;
        if (ins[31:10] == OP_BR)          cls = BR_BR;
        else if (ins[31:26] == OP_B)      cls = BR_B;
        else if (ins[31:26] == OP_BL)     cls = BR_BL;
        else if (ins[31:24] == OP_CBZ)    cls = BR_CBZ;
        else if (ins[31:24] == OP_CBNZ)   cls = BR_CBNZ;
        else if (ins[31:24] == OP_BCOND)  cls = BR_BCOND;
        return cls;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM-style condition evaluator: cond[3:0] against {N,Z,C,V}.
module cond_eval
    import legv8_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        taken = 1'b1;
        case (cond_e'(cond))
            CC_EQ:   taken = z;
            CC_NE:   taken = !z;
            CC_HS:   taken = c;
            CC_LO:   taken = !c;
            CC_MI:   taken = n;
            CC_PL:   taken = !n;
            CC_VS:   taken = v;
            CC_VC:   taken = !v;
            CC_HI:   taken = c && !z;
            CC_LS:   taken = !c || z;
            CC_GE:   taken = (n == v);
            CC_LT:   taken = (n != v);
            CC_GT:   taken = !z && (n == v);
            CC_LE:   taken = z || (n != v);
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle LEGv8 branch sequencer: walks one branch instruction through
// optional LINK/TEST cycles to EXEC, emitting one control word per cycle.
module branch_sequencer
    import legv8_ctrl_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int STATE_W     = 2,
    parameter int LINK_REG    = 30,
    parameter int FETCH_STATE = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [31:0]        instruction,
    input  logic [3:0]         flags,
    input  logic               alu_zero,
    output logic               ready,
    output logic               done,
    output logic               illegal,
    output logic [30:0]        controlWord,
    output logic [STATE_W-1:0] nextState,
    output logic [DATA_W-1:0]  K
);

    localparam logic [4:0]         LINK_DA  = 5'(LINK_REG);
    localparam logic [STATE_W-1:0] FETCH_NS = STATE_W'(FETCH_STATE);

    seq_state_e        state_q, state_d;
    br_class_e         cls_q, cls_d;
    logic [25:0]       imm_q, imm_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] k_q, k_d;

    logic              accept;
    logic              cond_taken;
    logic              br_taken;
    logic [DATA_W-1:0] off26;
    logic [DATA_W-1:0] off19;
    ctrl_word_t        cw;

    assign accept = start && (state_q == ST_IDLE);

    // Branch offsets are word counts; the <<2 turns them into byte offsets.
    assign off26 = {{(DATA_W-28){imm_q[25]}}, imm_q[25:0], 2'b00};
    assign off19 = {{(DATA_W-21){imm_q[23]}}, imm_q[23:5], 2'b00};

    cond_eval u_cond_eval (
        .cond  (imm_q[3:0]),
        .flags (flags),
        .taken (cond_taken)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cls_q   <= BR_ILLEGAL;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            k_q     <= k_d;
        end
    end

    // Instruction fields and the registered zero test are only read once a
    // branch has been accepted, so they need no reset.
    always_ff @(posedge clock) begin
        imm_q  <= imm_d;
        zero_q <= zero_d;
    end

    always_comb begin
        imm_d  = accept ? instruction[25:0] : imm_q;
        cls_d  = accept ? decode_class(instruction) : cls_q;
        zero_d = (state_q == ST_TEST) ? alu_zero : zero_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cls_d)
                        BR_BL:            state_d = ST_LINK;
                        BR_CBZ, BR_CBNZ:  state_d = ST_TEST;
                        BR_ILLEGAL:       state_d = ST_ERR;
                        default:          state_d = ST_EXEC;
                    endcase
                end
            end
            ST_LINK: state_d = ST_EXEC;
            ST_TEST: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cw       = CW_NOP;
        ready    = 1'b0;
        done     = 1'b0;
        illegal  = 1'b0;
        k_d      = k_q;
        br_taken = 1'b1;

        case (cls_q)
            BR_CBZ:   br_taken = zero_q;
            BR_CBNZ:  br_taken = !zero_q;
            BR_BCOND: br_taken = cond_taken;
            default:  br_taken = 1'b1;
        endcase

        case (state_q)
            ST_IDLE: ready = 1'b1;
            ST_LINK: begin
                cw.da    = LINK_DA;
                cw.reg_w = 1'b1;
                cw.en_pc = 1'b1;
            end
            ST_TEST: begin
                cw.sa   = imm_q[4:0];
                cw.fsel = ALU_PASS_A;
            end
            ST_EXEC: begin
                done = 1'b1;
                case (cls_q)
                    BR_B, BR_BL: begin
                        cw.psel = PSEL_PCK;
                        k_d     = off26;
                    end
                    BR_BR: begin
                        cw.psel  = PSEL_REG;
                        cw.sa    = imm_q[9:5];
                        cw.pcsel = 1'b1;
                    end
                    default: begin
                        if (br_taken) begin
                            cw.psel = PSEL_PCK;
                            k_d     = off19;
                        end else begin
                            cw.psel = PSEL_PC4;
                        end
                    end
                endcase
            end
            ST_ERR: begin
                done    = 1'b1;
                illegal = 1'b1;
            end
            default: cw = CW_NOP;
        endcase
    end

    assign controlWord = cw;
    assign K           = k_d;
    assign nextState   = done ? FETCH_NS : '0;

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomised self-checking bench for branch_sequencer against a behavioural
// model of branch classes, cycle counts, control words and K offsets.
module tb_branch_sequencer;
    import legv8_ctrl_pkg::ALU_PASS_A;

    localparam int C_ILL   = 0;
    localparam int C_B     = 1;
    localparam int C_BL    = 2;
    localparam int C_BR    = 3;
    localparam int C_CBZ   = 4;
    localparam int C_CBNZ  = 5;
    localparam int C_BCOND = 6;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] instruction;
    logic [3:0]  flags;
    logic        alu_zero;
    logic        ready;
    logic        done;
    logic        illegal;
    logic [30:0] controlWord;
    logic [1:0]  nextState;
    logic [63:0] K;

    int          n_checks;
    int          n_errors;
    logic [63:0] model_k;

    branch_sequencer #(
        .DATA_W      (64),
        .STATE_W     (2),
        .LINK_REG    (30),
        .FETCH_STATE (0)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .instruction (instruction),
        .flags       (flags),
        .alu_zero    (alu_zero),
        .ready       (ready),
        .done        (done),
        .illegal     (illegal),
        .controlWord (controlWord),
        .nextState   (nextState),
        .K           (K)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [30:0] mk_cw(input logic [1:0] ps, input logic [4:0] da,
                                          input logic [4:0] sa, input logic [4:0] sb,
                                          input logic [4:0] fs, input logic rw,
                                          input logic enpc, input logic pcs);
        return {ps, da, sa, sb, fs, rw, 4'b0000, enpc, 1'b0, pcs, 1'b0};
    endfunction

    function automatic logic [30:0] nop_cw();
        return mk_cw(2'b00, 5'd31, 5'd0, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic int classify(input logic [31:0] ins);
        if ((ins & 32'hFFFF_FC00) == 32'hD61F_0000) return C_BR;
        if (ins[31:26] == 6'd5)   return C_B;
        if (ins[31:26] == 6'd37)  return C_BL;
        if (ins[31:24] == 8'hB4)  return C_CBZ;
        if (ins[31:24] == 8'hB5)  return C_CBNZ;
        if (ins[31:24] == 8'h54)  return C_BCOND;
        return C_ILL;
    endfunction

    // Condition test in the architectural pairwise form: even codes test a
    // base predicate, odd codes invert it, except 1111 which is always true.
    function automatic bit cond_ref(input logic [3:0] cc, input logic [3:0] fl);
        bit n, z, c, v, r;
        {n, z, c, v} = fl;
        case (cc[3:1])
            3'd0:    r = z;
            3'd1:    r = c;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = c && !z;
            3'd5:    r = (n == v);
            3'd6:    r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (cc[0] && cc != 4'hF) r = !r;
        return r;
    endfunction

    function automatic logic [63:0] off26(input logic [31:0] ins);
        longint v;
        v = longint'(ins[25:0]);
        if (ins[25]) v = v - (longint'(1) << 26);
        return 64'(v * 4);
    endfunction

    function automatic logic [63:0] off19(input logic [31:0] ins);
        longint v;
        v = longint'(ins[23:5]);
        if (ins[23]) v = v - (longint'(1) << 19);
        return 64'(v * 4);
    endfunction

    // Entered and left at posedge+1 with the DUT idle.
    task automatic do_branch(input logic [31:0] ins, input logic z, input logic [3:0] fl,
                             input bit hold);
        int          cls;
        bit          tk;
        bit          exp_ill;
        logic [30:0] exp_cw;
        logic [63:0] exp_k;

        cls = classify(ins);
        instruction = ins;
        flags       = fl;
        alu_zero    = z;
        start       = 1'b1;
        @(posedge clock); #1;
        if (hold) instruction = $urandom();
        else      start = 1'b0;

        if (cls == C_BL || cls == C_CBZ || cls == C_CBNZ) begin
            if (cls == C_BL)
                exp_cw = mk_cw(2'b00, 5'd30, 5'd0, 5'd31, 5'd0, 1'b1, 1'b1, 1'b0);
            else
                exp_cw = mk_cw(2'b00, 5'd31, ins[4:0], 5'd31, ALU_PASS_A, 1'b0, 1'b0, 1'b0);
            check_val("cw_cycle1", controlWord, exp_cw);
            check_val("done_cycle1", done, 1'b0);
            check_val("ready_busy1", ready, 1'b0);
            check_val("k_hold_cycle1", K, model_k);
            @(posedge clock); #1;
        end

        exp_k   = model_k;
        exp_ill = 1'b0;
        case (cls)
            C_B, C_BL: begin
                exp_cw = mk_cw(2'b10, 5'd31, 5'd0, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0);
                exp_k  = off26(ins);
            end
            C_BR: exp_cw = mk_cw(2'b11, 5'd31, ins[9:5], 5'd31, 5'd0, 1'b0, 1'b0, 1'b1);
            C_CBZ, C_CBNZ, C_BCOND: begin
                if (cls == C_CBZ)       tk = z;
                else if (cls == C_CBNZ) tk = !z;
                else                    tk = cond_ref(ins[3:0], fl);
                if (tk) begin
                    exp_cw = mk_cw(2'b10, 5'd31, 5'd0, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0);
                    exp_k  = off19(ins);
                end else begin
                    exp_cw = mk_cw(2'b01, 5'd31, 5'd0, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0);
                end
            end
            default: begin
                exp_cw  = nop_cw();
                exp_ill = 1'b1;
            end
        endcase

        check_val("cw_final", controlWord, exp_cw);
        check_val("done_final", done, 1'b1);
        check_val("illegal_final", illegal, exp_ill);
        check_val("next_state_final", nextState, 2'd0);
        check_val("k_final", K, exp_k);
        check_val("ready_final", ready, 1'b0);
        start   = 1'b0;
        model_k = exp_k;

        @(posedge clock); #1;
        check_val("ready_after", ready, 1'b1);
        check_val("done_after", done, 1'b0);
        check_val("k_after", K, model_k);
    endtask

    task automatic reset_mid_link();
        instruction = 32'h97FF_FFFF;
        start       = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check_val("link_regw", controlWord[8], 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_ready", ready, 1'b1);
        check_val("rst_cw", controlWord, nop_cw());
        check_val("rst_regw", controlWord[8], 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_k", K, 64'd0);
        model_k = '0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) begin
            @(posedge clock); #1;
            check_val("post_rst_done", done, 1'b0);
            check_val("post_rst_ready", ready, 1'b1);
        end
    endtask

    initial begin
        logic [31:0] ins;
        n_checks    = 0;
        n_errors    = 0;
        model_k     = '0;
        reset_n     = 1'b0;
        start       = 1'b0;
        instruction = '0;
        flags       = '0;
        alu_zero    = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check_val("reset_ready", ready, 1'b1);
        check_val("reset_done", done, 1'b0);
        check_val("reset_illegal", illegal, 1'b0);
        check_val("reset_k", K, 64'd0);
        check_val("reset_next_state", nextState, 2'd0);
        check_val("reset_cw", controlWord, nop_cw());
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        do_branch(32'h1400_0010, 1'b0, 4'h0, 1'b0);
        do_branch(32'h97FF_FFFF, 1'b0, 4'h0, 1'b0);
        do_branch(32'hB400_0085, 1'b1, 4'h0, 1'b0);
        do_branch(32'hB400_0085, 1'b0, 4'h0, 1'b0);
        do_branch(32'hB500_0085, 1'b1, 4'h0, 1'b0);
        do_branch(32'hB500_0085, 1'b0, 4'h0, 1'b0);
        do_branch(32'h5400_004B, 1'b0, 4'b1000, 1'b0);
        do_branch(32'h5400_004B, 1'b0, 4'b1001, 1'b0);
        do_branch(32'hD61F_0140, 1'b0, 4'h0, 1'b0);
        do_branch(32'h8B00_0000, 1'b0, 4'h0, 1'b0);
        do_branch(32'h97FF_FFFF, 1'b1, 4'h0, 1'b1);
        do_branch(32'hB400_0085, 1'b1, 4'h0, 1'b1);

        for (int cc = 0; cc < 16; cc++) begin
            for (int rep = 0; rep < 2; rep++) begin
                ins = {8'h54, 19'($urandom()), 1'b0, 4'(cc)};
                do_branch(ins, 1'b0, 4'($urandom()), 1'b0);
            end
        end

        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 6))
                0:       ins = {6'd5, 26'($urandom())};
                1:       ins = {6'd37, 26'($urandom())};
                2:       ins = {22'h3587C0, 10'($urandom())};
                3:       ins = {8'hB4, 24'($urandom())};
                4:       ins = {8'hB5, 24'($urandom())};
                5:       ins = {8'h54, 24'($urandom())};
                default: ins = $urandom();
            endcase
            do_branch(ins, 1'($urandom()), 4'($urandom()), 1'($urandom()));
        end

        reset_mid_link();
        do_branch(32'h1400_0010, 1'b0, 4'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
